// File: rtl/sqrt_datapath.sv
// Square-root accelerator datapath: odd-number accumulation driven by
// a 9-bit control word from the controller FSM.
module sqrt_datapath #(
    parameter int W = 8
) (
    input  logic           clock,
    input  logic           reset,
    input  logic [8:0]     ctrl,
    input  logic [W-1:0]   din,
    output logic           flag,
    output logic [W/2-1:0] result,
    output logic           done
);

    localparam int H = W / 2;

    logic           x_ld;
    logic           s_ld;
    logic           s_sel;
    logic           d_ld;
    logic           d_sel;
    logic           f_ld;
    logic           r_ld;
    logic           dn_set;
    logic           clr;

    logic [W-1:0]   x;
    logic [W:0]     s;
    logic [H+1:0]   d;
    logic [H-1:0]   r;
    logic           f;
    logic           dn;

    logic [W:0]     d_ext;
    logic [H-1:0]   r_next;

    assign x_ld   = ctrl[8];
    assign s_ld   = ctrl[7];
    assign s_sel  = ctrl[6];
    assign d_ld   = ctrl[5];
    assign d_sel  = ctrl[4];
    assign f_ld   = ctrl[3];
    assign r_ld   = ctrl[2];
    assign dn_set = ctrl[1];
    assign clr    = ctrl[0];

    assign d_ext  = {{(H - 1){1'b0}}, d};
    // (D>>1)-1 truncated to H bits only needs D[H:1]
    assign r_next = d[H:1] - {{(H - 1){1'b0}}, 1'b1};

    always_ff @(posedge clock) begin
        if (!reset) begin
            x  <= '0;
            s  <= '0;
            d  <= {{(H + 1){1'b0}}, 1'b1};
            f  <= 1'b0;
            r  <= '0;
            dn <= 1'b0;
        end else begin
            if (x_ld)
                x <= din;
            if (clr) begin
                s  <= '0;
                d  <= {{(H + 1){1'b0}}, 1'b1};
                f  <= 1'b0;
                r  <= '0;
                dn <= 1'b0;
            end else begin
                if (s_ld)
                    s <= s_sel ? s + d_ext : '0;
                if (d_ld)
                    d <= d_sel ? d + {{H{1'b0}}, 2'd2}
                               : {{(H + 1){1'b0}}, 1'b1};
                if (f_ld)
                    f <= s > {1'b0, x};
                if (r_ld)
                    r <= r_next;
                dn <= dn_set;
            end
        end
    end

    assign flag   = f;
    assign result = r;
    assign done   = dn;

endmodule
